memwb_stage: RTL and testbench
==============================

# memwb_stage

Parametrised MEM/WB pipeline stage replacing the bare MEM/WB register bundle. It registers the memory-stage control and data fields behind a valid/ready handshake with a one-entry skid buffer, so the stage absorbs a writeback-side stall without a combinational ready path. It also supports flush, suppresses writes to x0, selects the writeback result, and counts retired instructions. It sits between the memory stage and the register-file write port and also feeds the hazard/forwarding unit.

## Interface
- XLEN, 32, datapath width of ALUResult, load_data, ImmExt, PCPlus4, result
- REG_AW, 5, destination register address width
- SKID_EN, 1, 1 = two-entry (main + skid) buffering; 0 = single register, ready_o = out_ready_i | !out_valid_o
- RET_W, 32, retire counter width
- clk  in  1  clock; one clock domain; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- flush_i  in  1  discard all buffered and incoming entries
- in_valid_i  in  1  memory stage presents an entry
- in_ready_o  out  1  stage accepts an entry this cycle
- in_regwrite_i  in  1  RegWrite control
- in_resultsrc_i  in  2  ResultSrc control
- in_alu_i, in_load_i, in_imm_i, in_pc4_i  in  XLEN each  ALUResult, load_data, ImmExt, PCPlus4
- in_rd_i  in  REG_AW  destination register
- out_valid_o  out  1  writeback entry valid
- out_ready_i  in  1  writeback consumes the entry
- out_regwrite_o  out  1  RegWrite after the x0 guard; 0 whenever out_valid_o = 0
- out_rd_o  out  REG_AW  destination register
- out_result_o  out  XLEN  selected writeback value
- retire_cnt_o  out  RET_W  count of output handshakes

## Operation
- Handshakes: the input fires on in_valid_i & in_ready_o. The output fires on out_valid_o & out_ready_i.
- Result select, done at capture: ResultSrc 00 → ALU, 01 → load, 10 → PCPlus4, 11 → ImmExt (lui).
- Capture stores the regwrite bit, rd, and the selected result.
- x0 guard: the stored regwrite is in_regwrite_i & (in_rd_i != 0).
- Buffer states (SKID_EN=1):
  - EMPTY → MAIN on input fire.
  - MAIN → FULL on input fire without output fire. The new entry goes to skid.
  - MAIN, input and output fire together: the new entry replaces main; state stays MAIN.
  - MAIN → EMPTY on output fire with no input fire.
  - FULL → MAIN on output fire. Skid moves to main.
- in_ready_o = (state != FULL). It is registered and has no combinational path from out_ready_i.
- Ordering is strictly FIFO; an entry is never dropped or duplicated.
- Flush: the next state is EMPTY and out_valid_o deasserts next cycle. An input presented in the flush cycle is dropped, and in_ready_o = 1 the following cycle. Flush has priority over every other event.
- Flush does not stop an output handshake in the same cycle. If out_valid_o & out_ready_i & flush_i, that entry still retires and is counted.
- retire_cnt_o increments by 1 on each output fire and wraps from 2^RET_W−1 to 0.

## Timing
- Reset values (asynchronous): state EMPTY, out_valid_o 0, in_ready_o 1, out_regwrite_o 0, out_rd_o 0, out_result_o 0, retire_cnt_o 0. These hold until the first rising edge after reset deasserts.
- Reset asserted mid-operation clears all entries immediately, without waiting for a clock edge.
- Latency: 1 cycle. An entry accepted at edge N is visible on the outputs after edge N.
- Throughput: 1 entry per cycle while out_ready_i = 1.
- Stall: after out_ready_i drops, at most one more entry is accepted. in_ready_o falls in the cycle after the skid entry fills.
- Output fields hold stable while out_valid_o & !out_ready_i.

## Structure
- Package memwb_pkg holds:
  - ResultSrc encodings RES_ALU=2'b00, RES_LOAD=2'b01, RES_PC4=2'b10, RES_IMM=2'b11.
  - Buffer state enum EMPTY/MAIN/FULL.
  - Packed wb_entry_t (regwrite, rd, result) at the default widths.
- Sub-module skid_buf, parametrised on payload width, implements the handshake, buffer state and flush.
- memwb_stage holds the result mux, the x0 guard and the retire counter, and instantiates skid_buf.

## Test plan
- Reset asserted mid-stream with FULL state → all outputs read 0 and in_ready_o reads 1 immediately, before any clock edge.
- Streaming: 4 back-to-back entries, out_ready_i=1, ResultSrc 00/01/10/11 with alu=0x10, load=0x20, pc4=0x30, imm=0x40 → out_result_o sequence 0x10,0x20,0x30,0x40, one per cycle; retire_cnt_o=4.
- Stall: out_ready_i=0 for 3 cycles during a stream → exactly 2 entries buffered, in_ready_o=0 from the next cycle. Release → entries emerge in order with no loss.
- x0 guard: rd=0, RegWrite=1, ResultSrc=00, ALU=0x5 → out_regwrite_o=0, out_result_o=0x5; entry still counted.
- Flush in FULL state, with in_valid_i=1 in the same cycle and out_ready_i=0 → out_valid_o=0 next cycle, in_ready_o=1, incoming entry absent, retire_cnt_o unchanged.
- Counter wrap: RET_W=4, 17 retirements → retire_cnt_o=1.

Source files
------------

// File: rtl/memwb_pkg.sv
// rtl/memwb_pkg.sv - shared encodings and types for the MEM/WB stage
package memwb_pkg;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMM  = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] result;
  } wb_entry_t;

endpackage

// File: rtl/memwb_stage_skid_buf.sv
// rtl/memwb_stage_skid_buf.sv - valid/ready register slice with optional one-entry skid and flush
module skid_buf
  import memwb_pkg::*;
#(
  parameter int W       = 38,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  buf_state_t   state_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_fire;
  logic         out_fire;

  // With the skid entry, ready is a pure decode of state: no path from out_ready_i.
  if (SKID_EN) begin : g_skid
    assign in_ready_o = (state_q != FULL);
  end else begin : g_noskid
    assign in_ready_o = out_ready_i | (state_q == EMPTY);
  end

  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_q  <= in_data_i;
            state_q <= MAIN;
          end
        end
        MAIN: begin
          if (in_fire && out_fire) begin
            main_q <= in_data_i;
          end else if (in_fire) begin
            skid_q  <= in_data_i;
            state_q <= FULL;
          end else if (out_fire) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q  <= skid_q;
            state_q <= MAIN;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/memwb_stage.sv
// rtl/memwb_stage.sv - MEM/WB stage: result select, x0 guard, skid buffering and retire count
module memwb_stage
  import memwb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter bit SKID_EN = 1'b1,
  parameter int RET_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_regwrite_i,
  input  logic [1:0]        in_resultsrc_i,
  input  logic [XLEN-1:0]   in_alu_i,
  input  logic [XLEN-1:0]   in_load_i,
  input  logic [XLEN-1:0]   in_imm_i,
  input  logic [XLEN-1:0]   in_pc4_i,
  input  logic [REG_AW-1:0] in_rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_regwrite_o,
  output logic [REG_AW-1:0] out_rd_o,
  output logic [XLEN-1:0]   out_result_o,
  output logic [RET_W-1:0]  retire_cnt_o
);

  localparam int PW = 1 + REG_AW + XLEN;

  logic [XLEN-1:0]  sel_result;
  logic             in_regwrite_g;
  logic [PW-1:0]    out_data;
  logic             out_regwrite_raw;
  logic [RET_W-1:0] retire_q;

  // Selecting at capture keeps only one XLEN value per buffered entry.
  always_comb begin
    sel_result = in_alu_i;
    case (in_resultsrc_i)
      RES_ALU:  sel_result = in_alu_i;
      RES_LOAD: sel_result = in_load_i;
      RES_PC4:  sel_result = in_pc4_i;
      RES_IMM:  sel_result = in_imm_i;
      default:  sel_result = in_alu_i;
    endcase
  end

  assign in_regwrite_g = in_regwrite_i & (in_rd_i != '0);

  skid_buf #(
    .W       (PW),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   ({in_regwrite_g, in_rd_i, sel_result}),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data)
  );

  assign {out_regwrite_raw, out_rd_o, out_result_o} = out_data;
  assign out_regwrite_o = out_valid_o & out_regwrite_raw;

  // A retire in the flush cycle still counts: flush never blocks the output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_q <= '0;
    end else if (out_valid_o && out_ready_i) begin
      retire_q <= retire_q + RET_W'(1);
    end
  end

  assign retire_cnt_o = retire_q;

endmodule

// File: tb/tb_memwb_stage.sv
// tb/tb_memwb_stage.sv - scoreboard bench for memwb_stage
module tb_memwb_stage;
  import memwb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        in_regwrite_i = 1'b0;
  logic [1:0]  in_resultsrc_i = 2'b00;
  logic [31:0] in_alu_i = '0;
  logic [31:0] in_load_i = '0;
  logic [31:0] in_imm_i = '0;
  logic [31:0] in_pc4_i = '0;
  logic [4:0]  in_rd_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        out_regwrite_o;
  logic [4:0]  out_rd_o;
  logic [31:0] out_result_o;
  logic [3:0]  retire_cnt_o;

  int          n_checks = 0;
  int          n_fail = 0;
  wb_entry_t   sbq[$];
  logic [3:0]  exp_cnt = '0;

  memwb_stage #(
    .XLEN(32), .REG_AW(5), .SKID_EN(1'b1), .RET_W(4)
  ) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_regwrite_i(in_regwrite_i), .in_resultsrc_i(in_resultsrc_i),
    .in_alu_i(in_alu_i), .in_load_i(in_load_i), .in_imm_i(in_imm_i), .in_pc4_i(in_pc4_i),
    .in_rd_i(in_rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_regwrite_o(out_regwrite_o), .out_rd_o(out_rd_o), .out_result_o(out_result_o),
    .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic wb_entry_t model_entry();
    wb_entry_t e;
    e.regwrite = in_regwrite_i && (in_rd_i != 5'd0);
    e.rd = in_rd_i;
    case (in_resultsrc_i)
      2'b00:   e.result = in_alu_i;
      2'b01:   e.result = in_load_i;
      2'b10:   e.result = in_pc4_i;
      default: e.result = in_imm_i;
    endcase
    return e;
  endfunction

  // Called at the negedge once inputs are set; books what the next posedge will do.
  task automatic sb_book(output logic popped, output wb_entry_t exp_e,
                         output logic exp_rdy, output logic exp_vld);
    exp_rdy = (sbq.size() < 2);
    exp_vld = (sbq.size() != 0);
    popped = 1'b0;
    exp_e = '0;
    if (out_valid_o && out_ready_i && sbq.size() != 0) begin
      exp_e = sbq.pop_front();
      popped = 1'b1;
      exp_cnt++;
    end
    if (flush_i) sbq.delete();
    else if (in_valid_i && in_ready_o) sbq.push_back(model_entry());
  endtask

  task automatic set_in(input logic v, input logic [1:0] rs, input logic [4:0] rd, input logic rw,
                        input logic [31:0] alu, input logic [31:0] ld,
                        input logic [31:0] pc4, input logic [31:0] imm);
    in_valid_i = v; in_resultsrc_i = rs; in_rd_i = rd; in_regwrite_i = rw;
    in_alu_i = alu; in_load_i = ld; in_pc4_i = pc4; in_imm_i = imm;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({out_valid_o, in_ready_o, out_regwrite_o} !== 3'b010) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 010", {out_valid_o, in_ready_o, out_regwrite_o});
    end
    n_checks++;
    if ({out_rd_o, out_result_o, retire_cnt_o} !== 41'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {out_rd_o, out_result_o, retire_cnt_o});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] tbl [4];
    logic p, r, v;
    wb_entry_t e;
    int npop = 0;
    tbl = '{32'h10, 32'h20, 32'h30, 32'h40};
    out_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) set_in(1'b1, c[1:0], 5'(c + 1), 1'b1, 32'h10, 32'h20, 32'h30, 32'h40);
      else in_valid_i = 1'b0;
      sb_book(p, e, r, v);
      n_checks++;
      if (p !== (c >= 1 && c <= 4)) begin
        n_fail++; $display("FAIL stream_timing: cycle %0d got pop %b", c, p);
      end
      if (p) begin
        n_checks++;
        if ({out_regwrite_o, out_rd_o, out_result_o} !== e) begin
          n_fail++; $display("FAIL stream_entry: got %h expected %h", {out_regwrite_o, out_rd_o, out_result_o}, e);
        end
        n_checks++;
        if (out_result_o !== tbl[npop]) begin
          n_fail++; $display("FAIL stream_result: got %h expected %h", out_result_o, tbl[npop]);
        end
        npop++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (retire_cnt_o !== 4'd4) begin
      n_fail++; $display("FAIL stream_retire: got %0d expected 4", retire_cnt_o);
    end
  endtask

  task automatic test_stall();
    logic p, r, v;
    wb_entry_t e;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) set_in(1'b1, RES_ALU, 5'(c + 1), 1'b1, 32'h100 + c, '0, '0, '0);
      else in_valid_i = 1'b0;
      out_ready_i = !(c >= 1 && c <= 3);
      sb_book(p, e, r, v);
      n_checks++;
      if (in_ready_o !== !(c >= 2 && c <= 4)) begin
        n_fail++; $display("FAIL stall_ready: cycle %0d got %b expected %b", c, in_ready_o, !(c >= 2 && c <= 4));
      end
      n_checks++;
      if ({in_ready_o, out_valid_o} !== {r, v}) begin
        n_fail++; $display("FAIL stall_occupancy: cycle %0d got %b expected %b", c, {in_ready_o, out_valid_o}, {r, v});
      end
      if (p) begin
        n_checks++;
        if ({out_regwrite_o, out_rd_o, out_result_o} !== e) begin
          n_fail++; $display("FAIL stall_entry: got %h expected %h", {out_regwrite_o, out_rd_o, out_result_o}, e);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (sbq.size() != 0 || out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain: got %0d pending valid %b expected 0 pending", sbq.size(), out_valid_o);
    end
  endtask

  task automatic test_x0();
    logic p, r, v;
    wb_entry_t e;
    out_ready_i = 1'b1;
    set_in(1'b1, RES_ALU, 5'd0, 1'b1, 32'h5, 32'h99, 32'h98, 32'h97);
    sb_book(p, e, r, v);
    @(negedge clk);
    in_valid_i = 1'b0;
    sb_book(p, e, r, v);
    n_checks++;
    if ({p, out_valid_o, out_regwrite_o} !== 3'b110) begin
      n_fail++; $display("FAIL x0_regwrite: got pop/valid/rw %b expected 110", {p, out_valid_o, out_regwrite_o});
    end
    n_checks++;
    if (out_result_o !== 32'h5) begin
      n_fail++; $display("FAIL x0_result: got %h expected 00000005", out_result_o);
    end
    @(negedge clk);
    n_checks++;
    if (retire_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL x0_retire: got %0d expected %0d", retire_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_flush();
    logic p, r, v;
    wb_entry_t e;
    out_ready_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      set_in(1'b1, RES_LOAD, 5'(c + 7), 1'b1, '0, 32'h700 + c, '0, '0);
      sb_book(p, e, r, v);
      @(negedge clk);
    end
    set_in(1'b1, RES_ALU, 5'd9, 1'b1, 32'hDEAD, '0, '0, '0);
    flush_i = 1'b1;
    sb_book(p, e, r, v);
    @(negedge clk);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    n_checks++;
    if ({out_valid_o, in_ready_o, out_regwrite_o} !== 3'b010) begin
      n_fail++; $display("FAIL flush_full: got valid/ready/rw %b expected 010", {out_valid_o, in_ready_o, out_regwrite_o});
    end
    n_checks++;
    if (retire_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL flush_retire: got %0d expected %0d", retire_cnt_o, exp_cnt);
    end
    out_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sb_book(p, e, r, v);
      n_checks++;
      if (out_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL flush_absent: cycle %0d got valid %b expected 0", c, out_valid_o);
      end
      @(negedge clk);
    end
    // Output handshake coinciding with flush must still retire.
    out_ready_i = 1'b0;
    set_in(1'b1, RES_IMM, 5'd3, 1'b1, '0, '0, '0, 32'h4444);
    sb_book(p, e, r, v);
    @(negedge clk);
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    flush_i = 1'b1;
    sb_book(p, e, r, v);
    n_checks++;
    if (!p || {out_regwrite_o, out_rd_o, out_result_o} !== e) begin
      n_fail++; $display("FAIL flush_retire_entry: got %h expected %h", {out_regwrite_o, out_rd_o, out_result_o}, e);
    end
    @(negedge clk);
    flush_i = 1'b0;
    n_checks++;
    if ({out_valid_o, retire_cnt_o} !== {1'b0, exp_cnt}) begin
      n_fail++; $display("FAIL flush_with_fire: got valid %b cnt %0d expected 0 cnt %0d", out_valid_o, retire_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    logic p, r, v;
    wb_entry_t e;
    out_ready_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      set_in(1'b1, RES_PC4, 5'(c + 20), 1'b1, '0, '0, 32'hABC0 + c, '0);
      sb_book(p, e, r, v);
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid_o, in_ready_o, out_regwrite_o} !== 3'b010) begin
      n_fail++; $display("FAIL midreset_flags: got %b expected 010", {out_valid_o, in_ready_o, out_regwrite_o});
    end
    n_checks++;
    if ({out_rd_o, out_result_o, retire_cnt_o} !== 41'd0) begin
      n_fail++; $display("FAIL midreset_data: got %h expected 0", {out_rd_o, out_result_o, retire_cnt_o});
    end
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    exp_cnt = '0;
  endtask

  task automatic test_wrap();
    logic p, r, v;
    wb_entry_t e;
    out_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 17) set_in(1'b1, 2'(c), 5'(c + 1), c[0], 32'h1000 + c, 32'h2000 + c, 32'h3000 + c, 32'h4000 + c);
      else in_valid_i = 1'b0;
      sb_book(p, e, r, v);
      if (p) begin
        n_checks++;
        if ({out_regwrite_o, out_rd_o, out_result_o} !== e) begin
          n_fail++; $display("FAIL wrap_entry: got %h expected %h", {out_regwrite_o, out_rd_o, out_result_o}, e);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (retire_cnt_o !== 4'd1) begin
      n_fail++; $display("FAIL wrap_retire: got %0d expected 1", retire_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_x0();
    test_flush();
    test_reset_midstream();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
